// File: rtl/mem_pkg.sv
// mem_pkg: encodings and helpers shared by the store buffer and the data memory.
//   MEM_WORD/MEM_HALF/MEM_BYTE : MemNum size encodings (11/10/01, 00 invalid)
//   sb_entry_t / ENTRY_W       : one queued store {addr, data, num}
//   size_bytes()               : MemNum -> byte count (0 for invalid)
//   aligned()                  : natural-alignment check, false for invalid size
package mem_pkg;

  localparam logic [1:0] MEM_WORD = 2'b11;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  num;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

  function automatic logic [2:0] size_bytes(input logic [1:0] num);
    case (num)
      MEM_WORD: return 3'd4;
      MEM_HALF: return 3'd2;
      MEM_BYTE: return 3'd1;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic aligned(input logic [1:0] num, input logic [1:0] lsb);
    case (num)
      MEM_WORD: return lsb == 2'b00;
      MEM_HALF: return !lsb[0];
      MEM_BYTE: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: DEPTH-entry register FIFO holding queued stores.
//   clk_i, rst_i  : clock, async active-low reset
//   push_i/entry_i: write entry at tail (ignored when full)
//   pop_i         : drop head (ignored when empty)
//   head_o        : entry at head
//   count_o       : occupancy, 0..DEPTH
//   valid_o/entries_o : per-slot valid bits and contents for overlap compare
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              push_i,
  input  logic [ENTRY_W-1:0]                entry_i,
  input  logic                              pop_i,
  output logic [ENTRY_W-1:0]                head_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic [DEPTH-1:0]                  valid_o,
  output logic [DEPTH-1:0][ENTRY_W-1:0]     entries_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][ENTRY_W-1:0] slot_q;
  logic [DEPTH-1:0]              valid_q;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 cnt;
  logic                          do_push, do_pop;

  assign do_push = push_i && (cnt < CW'(DEPTH));
  assign do_pop  = pop_i && (cnt != '0);

  // Pointers wrap naturally since DEPTH is a power of two. Push and pop can
  // only hit the same slot when the FIFO is empty (pop suppressed) or full
  // (push suppressed), so the valid clear/set below never collide.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_q  <= '0;
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        valid_q[wr_ptr] <= 1'b1;
        slot_q[wr_ptr]  <= entry_i;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_o    = slot_q[rd_ptr];
  assign count_o   = cnt;
  assign valid_o   = valid_q;
  assign entries_o = slot_q;

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: store queue in front of the data memory write port.
//   clk_i, rst_i            : clock, async active-low reset
//   st_valid_i/st_ready_o   : store handshake from execute stage
//   st_addr_i/st_data_i/st_num_i : store byte address, right-aligned data, size
//   ld_req_i/ld_addr_i/ld_num_i  : load being issued, checked for overlap
//   ld_conflict_o           : load touches a byte still waiting to be written
//   drain_hold_i            : stall draining
//   mem_write_o/mem_addr_o/mem_data_o/mem_num_o : registered memory write port
//   empty_o                 : nothing queued and nothing being written
//   error_misaligned_o/error_overflow_o : sticky reject flags
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_valid_i,
  output logic        st_ready_o,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_num_i,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [1:0]  ld_num_i,
  output logic        ld_conflict_o,
  input  logic        drain_hold_i,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [1:0]  mem_num_o,
  output logic        empty_o,
  output logic        error_misaligned_o,
  output logic        error_overflow_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]                 count;
  logic [DEPTH-1:0]              valid;
  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  sb_entry_t                     head, new_entry, e;
  logic [32:0]                   st_end;
  logic                          bad_align, bad_range, accept, push, pop, hit;

  // Byte-range intersection; ends are exclusive and computed in 33 bits so a
  // range touching the top of the address space does not wrap.
  function automatic logic overlap(input logic [31:0] a, input logic [2:0] asz,
                                   input logic [31:0] b, input logic [2:0] bsz);
    logic [32:0] a_end, b_end;
    a_end = {1'b0, a} + {30'b0, asz};
    b_end = {1'b0, b} + {30'b0, bsz};
    return (asz != 3'd0) && (bsz != 3'd0) && ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
  endfunction

  assign st_ready_o = count < CW'(DEPTH);
  assign accept     = st_valid_i && st_ready_o;
  assign bad_align  = !aligned(st_num_i, st_addr_i[1:0]);
  assign st_end     = {1'b0, st_addr_i} + {30'b0, size_bytes(st_num_i)};
  assign bad_range  = st_end > 33'(MEM_BYTES);
  assign push       = accept && !bad_align && !bad_range;
  assign pop        = (count != '0) && !drain_hold_i;
  assign new_entry  = '{addr: st_addr_i, data: st_data_i, num: st_num_i};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .entry_i   (new_entry),
    .pop_i     (pop),
    .head_o    (head),
    .count_o   (count),
    .valid_o   (valid),
    .entries_o (entries)
  );

  // The entry on the memory port has left the FIFO but is not committed
  // until the next edge, so it still blocks overlapping loads.
  always_comb begin
    e   = '0;
    hit = mem_write_o && overlap(mem_addr_o, size_bytes(mem_num_o), ld_addr_i, size_bytes(ld_num_i));
    for (int i = 0; i < DEPTH; i++) begin
      e = sb_entry_t'(entries[i]);
      if (valid[i] && overlap(e.addr, size_bytes(e.num), ld_addr_i, size_bytes(ld_num_i)))
        hit = 1'b1;
    end
  end

  assign ld_conflict_o = ld_req_i && hit;
  assign empty_o       = (count == '0) && !mem_write_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_write_o        <= 1'b0;
      mem_addr_o         <= '0;
      mem_data_o         <= '0;
      mem_num_o          <= 2'b00;
      error_misaligned_o <= 1'b0;
      error_overflow_o   <= 1'b0;
    end else begin
      mem_write_o <= pop;
      if (pop) begin
        mem_addr_o <= head.addr;
        mem_data_o <= head.data;
        mem_num_o  <= head.num;
      end
      if (accept && bad_align) error_misaligned_o <= 1'b1;
      if (accept && bad_range) error_overflow_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  localparam int DEPTH     = 4;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0, rst_i = 1'b1;
  logic        st_valid, st_ready_o, ld_req, ld_conflict_o, drain_hold;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [1:0]  st_num, ld_num;
  logic        mem_write_o, empty_o, error_misaligned_o, error_overflow_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [1:0]  mem_num_o;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(DEPTH), .MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .st_valid_i(st_valid), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr), .st_data_i(st_data), .st_num_i(st_num),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_num_i(ld_num),
    .ld_conflict_o(ld_conflict_o), .drain_hold_i(drain_hold),
    .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_num_o(mem_num_o),
    .empty_o(empty_o),
    .error_misaligned_o(error_misaligned_o), .error_overflow_o(error_overflow_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint      addr;
    logic [31:0] data;
    logic [1:0]  num;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  logic        m_wr, m_emis, m_eovf;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_num;

  function automatic int nbytes(input logic [1:0] n);
    return (n == 2'b11) ? 4 : (n == 2'b10) ? 2 : (n == 2'b01) ? 1 : 0;
  endfunction

  function automatic bit ovl(input longint a, input int as, input longint b, input int bs);
    return as > 0 && bs > 0 && a < b + bs && b < a + as;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    bit     rdy, bad_al, bad_rg;
    int     sz;
    longint a;
    if (!rst_i) begin
      m_q.delete();
      m_wr = 0; m_addr = 0; m_data = 0; m_num = 0; m_emis = 0; m_eovf = 0;
    end else begin
      rdy = m_q.size() < DEPTH;
      if (m_q.size() > 0 && !drain_hold) begin
        m_e    = m_q.pop_front();
        m_wr   = 1;
        m_addr = m_e.addr[31:0];
        m_data = m_e.data;
        m_num  = m_e.num;
      end else m_wr = 0;
      if (st_valid && rdy) begin
        sz     = nbytes(st_num);
        a      = longint'(st_addr);
        bad_al = (sz == 0) || (a % sz != 0);
        bad_rg = a + sz > MEM_BYTES;
        if (bad_al) m_emis = 1;
        if (bad_rg) m_eovf = 1;
        if (!bad_al && !bad_rg) begin
          m_e.addr = a; m_e.data = st_data; m_e.num = st_num;
          m_q.push_back(m_e);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit c;
    c = m_wr && ovl(longint'(m_addr), nbytes(m_num), longint'(ld_addr), nbytes(ld_num));
    foreach (m_q[i])
      if (ovl(m_q[i].addr, nbytes(m_q[i].num), longint'(ld_addr), nbytes(ld_num))) c = 1;
    chk("m_ready",    st_ready_o,         m_q.size() < DEPTH);
    chk("m_wr",       mem_write_o,        m_wr);
    chk("m_addr",     mem_addr_o,         m_addr);
    chk("m_data",     mem_data_o,         m_data);
    chk("m_num",      mem_num_o,          m_num);
    chk("m_empty",    empty_o,            m_q.size() == 0 && !m_wr);
    chk("m_emis",     error_misaligned_o, m_emis);
    chk("m_eovf",     error_overflow_o,   m_eovf);
    chk("m_conflict", ld_conflict_o,      ld_req && c);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] n);
    st_valid = 1; st_addr = a; st_data = d; st_num = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    st_valid = 0; st_addr = 0; st_data = 0; st_num = 0;
    ld_req = 0; ld_addr = 0; ld_num = 0; drain_hold = 0;
    #1 rst_i = 0;
    tick(); tick();
    chk("rst_wr", mem_write_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", st_ready_o, 1);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_emis", error_misaligned_o, 0);
    chk("rst_eovf", error_overflow_o, 0);
    rst_i = 1;
    tick();

    // single word store and its latency
    drive_st(32'h10, 32'hDEADBEEF, 2'b11);
    tick(); st_valid = 0;
    chk("t1_wr_early", mem_write_o, 0);
    chk("t1_not_empty", empty_o, 0);
    tick();
    chk("t1_wr", mem_write_o, 1);
    chk("t1_addr", mem_addr_o, 32'h10);
    chk("t1_data", mem_data_o, 32'hDEADBEEF);
    chk("t1_num", mem_num_o, 2'b11);
    tick();
    chk("t1_wr_done", mem_write_o, 0);
    chk("t1_empty", empty_o, 1);
    chk("t1_addr_hold", mem_addr_o, 32'h10);

    // fill while held, overfill attempt, then ordered drain
    drain_hold = 1;
    for (int i = 0; i < 4; i++) begin
      drive_st(32'h20 + i, 32'hA0 + i, 2'b01);
      tick();
    end
    st_valid = 0;
    chk("t2_full", st_ready_o, 0);
    drive_st(32'h24, 32'hFF, 2'b01);
    tick(); st_valid = 0;
    chk("t2_still_full", st_ready_o, 0);
    drain_hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_wr", mem_write_o, 1);
      chk("t2_addr", mem_addr_o, 32'h20 + i);
      chk("t2_data", mem_data_o, 32'hA0 + i);
    end
    tick();
    chk("t2_no_fifth", mem_write_o, 0);
    chk("t2_empty", empty_o, 1);

    // load overlap detection
    drain_hold = 1;
    drive_st(32'h42, 32'hBEEF, 2'b10);
    tick(); st_valid = 0;
    ld_req = 1; ld_addr = 32'h40; ld_num = 2'b11; #1;
    chk("t3_word_hit", ld_conflict_o, 1);
    ld_addr = 32'h44; ld_num = 2'b01; #1;
    chk("t3_byte_miss", ld_conflict_o, 0);
    ld_addr = 32'h43; #1;
    chk("t3_last_byte_hit", ld_conflict_o, 1);
    ld_addr = 32'h41; #1;
    chk("t3_prev_byte_miss", ld_conflict_o, 0);
    ld_addr = 32'h40; ld_num = 2'b11; drain_hold = 0;
    tick();
    chk("t3_presented_hit", ld_conflict_o, 1);
    tick();
    chk("t3_drained_miss", ld_conflict_o, 0);
    ld_req = 0;

    // rejects and range edges
    drive_st(32'h400, 32'h1, 2'b01);
    tick(); st_valid = 0;
    chk("t4_ovf", error_overflow_o, 1);
    chk("t4_mis_clear", error_misaligned_o, 0);
    chk("t4_ovf_empty", empty_o, 1);
    drive_st(32'h3FF, 32'h5A, 2'b01);
    tick(); st_valid = 0;
    chk("t4_top_byte_ok", empty_o, 0);
    tick();
    chk("t4_top_addr", mem_addr_o, 32'h3FF);
    drive_st(32'h31, 32'h1234, 2'b10);
    tick(); st_valid = 0;
    chk("t4_mis", error_misaligned_o, 1);
    tick();
    chk("t4_mis_sticky", error_misaligned_o, 1);
    chk("t4_mis_empty", empty_o, 1);
    drive_st(32'h3FE, 32'h0, 2'b11);
    tick(); st_valid = 0;
    chk("t4_word_ovf", error_overflow_o, 1);
    chk("t4_word_empty", empty_o, 1);

    // simultaneous push/pop at count=2 across pointer wrap
    drain_hold = 1;
    drive_st(32'h100, 32'h1000, 2'b11); tick();
    drive_st(32'h104, 32'h1001, 2'b11); tick();
    drain_hold = 0;
    for (int k = 0; k < 10; k++) begin
      drive_st(32'h108 + 4 * k, 32'h1002 + k, 2'b11);
      tick();
      chk("t5_wr", mem_write_o, 1);
      chk("t5_addr", mem_addr_o, 32'h100 + 4 * k);
      chk("t5_data", mem_data_o, 32'h1000 + k);
      chk("t5_ready", st_ready_o, 1);
    end
    st_valid = 0;
    tick(); chk("t5_tail0", mem_addr_o, 32'h128);
    tick(); chk("t5_tail1", mem_addr_o, 32'h12C);
    tick(); chk("t5_idle", mem_write_o, 0);

    // reset mid-burst discards everything
    drain_hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive_st(32'h200 + 4 * i, 32'h2000 + i, 2'b11);
      tick();
    end
    st_valid = 0; drain_hold = 0;
    tick();
    chk("t6_wr_before", mem_write_o, 1);
    chk("t6_addr_before", mem_addr_o, 32'h200);
    rst_i = 0; #1;
    chk("t6_wr_drop", mem_write_o, 0);
    chk("t6_empty", empty_o, 1);
    chk("t6_addr_clr", mem_addr_o, 0);
    chk("t6_emis_clr", error_misaligned_o, 0);
    tick(); tick();
    rst_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_write", mem_write_o, 0);
      chk("t6_stay_empty", empty_o, 1);
    end

    // invalid size after a clean reset
    drive_st(32'h50, 32'h0, 2'b00);
    tick(); st_valid = 0;
    chk("t7_size00_mis", error_misaligned_o, 1);
    chk("t7_size00_no_ovf", error_overflow_o, 0);
    chk("t7_size00_empty", empty_o, 1);
    drive_st(32'hFFFFFFFC, 32'h0, 2'b11);
    tick(); st_valid = 0;
    chk("t7_wrap_ovf", error_overflow_o, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
Write buffer directly upstream of the data memory write port in the single-cycle MIPS datapath.
- Accepts byte/half/word stores from the execute stage and queues them in a small FIFO.
- Drains one entry per clock into the data memory's MemWrite/MemNum/addr/data inputs.
- Flags loads that overlap any queued store, so the CPU stalls until that data has been drained.

Parameters:
DEPTH, 4, number of queued stores; power of two, minimum 2.
MEM_BYTES, 1024, data memory size in bytes; used for the address range check.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous active-low reset
st_valid_i  input  1  store request from execute stage
st_ready_o  output  1  buffer can accept a store this cycle
st_addr_i  input  32  store byte address (big-endian)
st_data_i  input  32  store data, right-aligned (half in [15:0], byte in [7:0])
st_num_i  input  2  size: 2'b11 word, 2'b10 half, 2'b01 byte
ld_req_i  input  1  a load is being issued this cycle
ld_addr_i  input  32  load byte address
ld_num_i  input  2  load size, same encoding as st_num_i
ld_conflict_o  output  1  load overlaps a queued store; CPU must stall
drain_hold_i  input  1  suppress draining this cycle (debug/test)
mem_write_o  output  1  to data memory MemWrite
mem_addr_o  output  32  to data memory address
mem_data_o  output  32  to data memory write data
mem_num_o  output  2  to data memory MemNum
empty_o  output  1  no stores queued
error_misaligned_o  output  1  sticky; a store was rejected for misalignment or bad size
error_overflow_o  output  1  sticky; a store was rejected for out-of-range address

Behaviour:
- Reset (rst_i low, asynchronous): all entries invalid; pointers and count 0; mem_write_o=0; mem_addr_o/mem_data_o=0; mem_num_o=2'b00; empty_o=1; st_ready_o=1; both error flags 0. Reset mid-operation discards queued stores; none are written.
- Size decode: 11->4 bytes, 10->2, 01->1, 00->invalid.
- Accept condition: st_valid_i && st_ready_o. st_ready_o = (count < DEPTH), computed from registered state only; it does not depend on a same-cycle drain.
- Validity checks on every accept:
  - Size invalid, or half with addr[0]!=0, or word with addr[1:0]!=0: store is not queued; error_misaligned_o is set.
  - addr + size > MEM_BYTES, evaluated in 33-bit arithmetic so wrap-around counts as overflow: store is not queued; error_overflow_o is set.
  - If both checks fail, both flags are set.
  - Error flags clear only on reset.
- Enqueue: entry {addr, data, num} is written at the tail on the accepting edge.
- Drain:
  - mem_* outputs are registered.
  - At each rising edge with the FIFO non-empty and drain_hold_i=0: the head is popped, loaded into mem_addr_o/mem_data_o/mem_num_o, and mem_write_o=1 for the following cycle.
  - Otherwise mem_write_o=0 and the other mem_* outputs hold their last values.
  - Latency: a store accepted at edge N into an empty buffer presents mem_write_o=1 in cycle N+1 and commits to memory at edge N+2.
- Simultaneous accept and drain: count unchanged. Push while full is impossible because ready is low. Pop while empty does nothing.
- Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits wide.
- ld_conflict_o (combinational):
  - Equals ld_req_i AND (at least one valid queued entry, or the entry currently presented with mem_write_o=1, whose byte range [addr, addr+size-1] intersects [ld_addr_i, ld_addr_i+ld_size-1]).
  - A store being accepted in the same cycle is not compared; the CPU issues one instruction per cycle.
- empty_o = (count==0) && !mem_write_o, i.e. memory is fully up to date.

Decomposition:
- Shared package mem_pkg:
  - MEM_WORD/MEM_HALF/MEM_BYTE encodings (11/10/01), shared with the data memory.
  - Size-in-bytes function.
  - Alignment-check function.
- One sub-module, sb_fifo: DEPTH-entry register FIFO with push/pop, head output, and a flat valid+entry vector exposed for the overlap comparators.
- Overlap comparators and error logic stay in mem_store_buffer.

Test Plan:
- Reset then single word store 0x10 / 0xDEADBEEF at edge 1 -> mem_write_o=1, mem_addr_o=0x10, mem_data_o=0xDEADBEEF, mem_num_o=11 in cycle 2; empty_o=1 from cycle 3.
- drain_hold_i=1, push 4 byte stores to 0x20..0x23 -> st_ready_o=0 after the 4th; 5th st_valid_i ignored; release hold -> writes emitted in order 0x20,0x21,0x22,0x23 on consecutive cycles.
- Hold with a queued half store at 0x42; load word at 0x40 -> ld_conflict_o=1; load byte at 0x44 -> 0; after drain completes, word load at 0x40 -> 0.
- Half store to 0x31 -> not queued, error_misaligned_o=1 and stays 1; word store to 0x3FE (MEM_BYTES=1024) -> error_overflow_o=1; st_num_i=00 -> error_misaligned_o.
- Simultaneous push and pop with count=2 over 10 cycles -> count stays 2; order preserved across pointer wrap.
- Assert rst_i low mid-burst with 3 entries queued -> mem_write_o drops immediately, empty_o=1, no further writes after release.
